// File: rtl/leaf_user_pkg.sv
// Shared constants and types for the per-port leaf user-side adapters.
package leaf_user_pkg;

  localparam int PAYLOAD_BITS_DEFAULT = 32;
  localparam int NUM_PORT_MAX         = 7;

  typedef logic [PAYLOAD_BITS_DEFAULT-1:0] payload_t;

endpackage

// File: rtl/leaf_user_sync_fifo.sv
// Single-clock FIFO with a registered read-data port; the read register doubles
// as the holding register for the word currently presented downstream.
module leaf_user_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_BITS:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_W = (DEPTH_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q;
  logic [DEPTH_BITS-1:0] rd_ptr_q;
  logic [DEPTH_BITS:0]   count_q;
  logic [WIDTH-1:0]      rd_data_q;
  logic                  rd_fire;

  assign full_o    = (count_q == DEPTH_W);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = rd_data_q;
  assign rd_fire   = rd_en_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({wr_en_i, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/leaf_user_in_adapter.sv
// Input adapter: leaf interface vld/ack channel into a kernel ready/valid stream,
// with credit-limited ack generation and a saturating delivered-word counter.
module leaf_user_in_adapter
  import leaf_user_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEFAULT,
  parameter int DEPTH_BITS   = 3,
  parameter int CNT_BITS     = 32
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DEPTH_BITS:0]     occupancy,
  output logic [CNT_BITS-1:0]     word_cnt
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS+1:0] CAPACITY = (DEPTH_BITS+2)'(DEPTH + 1);

  logic                  ack_q, ack_d;
  logic                  tvalid_q, tvalid_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  wr_en, rd_en, out_hs, out_free;
  logic                  fifo_full, fifo_empty;
  logic [DEPTH_BITS:0]   fifo_count;
  logic [DEPTH_BITS+1:0] committed;
  logic                  space_ok;

  assign wr_en    = ack_q & vld_interface2user;
  assign out_hs   = tvalid_q & m_tready;
  assign out_free = ~tvalid_q | m_tready;
  assign rd_en    = out_free & ~fifo_empty;

  // Capacity counts the FIFO plus the output register; an ack in flight
  // already owns a slot.
  assign occupancy = fifo_count + {{DEPTH_BITS{1'b0}}, tvalid_q};
  assign committed = {1'b0, occupancy} + {{(DEPTH_BITS+1){1'b0}}, ack_q};
  assign space_ok  = (committed < CAPACITY);

  leaf_user_sync_fifo #(
    .WIDTH      (PAYLOAD_BITS),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk_i     (clk_user),
    .rst_i     (reset),
    .wr_en_i   (wr_en),
    .wr_data_i (dout_leaf_interface2user),
    .rd_en_i   (rd_en),
    .rd_data_o (m_tdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_comb begin
    ack_d    = vld_interface2user & ~ack_q & space_ok;
    tvalid_d = tvalid_q;
    if (out_free) tvalid_d = ~fifo_empty;
    cnt_d = cnt_q;
    if (out_hs && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      ack_q    <= 1'b0;
      tvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      tvalid_q <= tvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_user) begin
    if (!reset) assert (!(wr_en && fifo_full));
  end

  assign ack_user2interface = ack_q;
  assign m_tvalid           = tvalid_q;
  assign word_cnt           = cnt_q;

endmodule

// File: tb/tb_leaf_user_in_adapter.sv
// Scoreboard bench: a leaf-interface model feeds words, a monitor checks the
// kernel-side stream, occupancy and counters against a queue of consumed words.
module tb_leaf_user_in_adapter;

  logic        clk_user = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din;
  logic        vld;
  logic        m_tready = 1'b0;

  logic        ack, m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  occupancy;
  logic [31:0] word_cnt;

  logic        ack_s, tvalid_s;
  logic [31:0] tdata_s;
  logic [3:0]  occ_s;
  logic [3:0]  cnt_s;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          gap_pct = 0;
  int          cons_cnt = 0;
  logic [31:0] tx_q[$];
  logic [31:0] exp_q[$];
  int unsigned exp_cnt = 0;

  always #5 clk_user = ~clk_user;
  always @(posedge clk_user) cyc <= cyc + 1;

  leaf_user_in_adapter u_dut (
    .clk_user                 (clk_user),
    .reset                    (rst),
    .dout_leaf_interface2user (din),
    .vld_interface2user       (vld),
    .ack_user2interface       (ack),
    .m_tdata                  (m_tdata),
    .m_tvalid                 (m_tvalid),
    .m_tready                 (m_tready),
    .occupancy                (occupancy),
    .word_cnt                 (word_cnt)
  );

  leaf_user_in_adapter #(.CNT_BITS(4)) u_sat (
    .clk_user                 (clk_user),
    .reset                    (rst),
    .dout_leaf_interface2user (din),
    .vld_interface2user       (vld),
    .ack_user2interface       (ack_s),
    .m_tdata                  (tdata_s),
    .m_tvalid                 (tvalid_s),
    .m_tready                 (m_tready),
    .occupancy                (occ_s),
    .word_cnt                 (cnt_s)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_user);
      #2;
    end
  endtask

  task automatic wait_drain(input string name, input int budget, input bit rand_rdy);
    int i = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0 || m_tvalid) && i < budget) begin
      if (rand_rdy) m_tready = ($urandom_range(1) == 1);
      step(1);
      i++;
    end
    chk(name, longint'(i < budget), 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Leaf interface model: holds a word until acked, then advances next cycle.
  initial begin
    int seen = 0;
    vld = 1'b0;
    din = '0;
    forever begin
      @(posedge clk_user);
      #1;
      if (cons_cnt != seen) begin
        seen = cons_cnt;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
        vld = 1'b0;
      end
      if (!vld && tx_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        vld = 1'b1;
        din = tx_q[0];
      end
    end
  end

  // Monitor: values seen here are the ones the next rising edge acts on.
  initial begin
    logic        prev_ack = 1'b0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_d = '0;
    logic [31:0] e;
    forever begin
      @(negedge clk_user);
      if (rst) begin
        exp_q.delete();
        exp_cnt  = 0;
        hold_v   = 1'b0;
        prev_ack = 1'b0;
      end else begin
        chk("occupancy", occupancy, exp_q.size());
        chk("sat_occupancy", occ_s, exp_q.size());
        chk("occ_bound", longint'(occupancy > 4'd9), 0);
        chk("word_cnt", word_cnt, exp_cnt);
        chk("sat_word_cnt", cnt_s, (exp_cnt > 15) ? 15 : exp_cnt);
        if (ack) begin
          chk("ack_back_to_back", prev_ack, 0);
          chk("ack_without_vld", vld, 1);
        end
        if (ack_s) chk("sat_ack_without_vld", vld, 1);
        prev_ack = ack;
        if (hold_v) begin
          chk("tvalid_hold", m_tvalid, 1);
          chk("tdata_hold", m_tdata, hold_d);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_output", m_tdata, 32'hxxxx_xxxx === m_tdata ? 0 : ~m_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("data", m_tdata, e);
            chk("sat_tvalid", tvalid_s, 1);
            chk("sat_tdata", tdata_s, e);
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
          end
          hold_v = 1'b0;
        end else if (m_tvalid) begin
          hold_v = 1'b1;
          hold_d = m_tdata;
        end else begin
          hold_v = 1'b0;
        end
        if (vld && ack) begin
          exp_q.push_back(din);
          cons_cnt++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cv, ca, ct, nack, found, n_left;
    logic [31:0] head;

    // Reset state
    rst = 1'b1;
    step(3);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_tdata", m_tdata, 0);
    rst = 1'b0;
    step(2);

    // Single word with latency checks
    m_tready = 1'b1;
    tx_q.push_back(32'hDEAD_BEEF);
    cv = -1; ca = -1; ct = -1; nack = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (vld && cv < 0) cv = cyc;
      if (ack) begin
        nack++;
        if (ca < 0) ca = cyc;
      end
      if (m_tvalid && ct < 0) ct = cyc;
    end
    chk("single_ack_delay", ca - cv, 1);
    chk("single_tvalid_delay", ct - ca, 2);
    chk("single_ack_count", nack, 1);
    chk("single_word_cnt", word_cnt, 1);

    // Burst under backpressure, then release
    pulse_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) tx_q.push_back(32'h0000_0100 + i);
    step(60);
    chk("burst_occupancy", occupancy, 9);
    chk("burst_accepted", 20 - tx_q.size(), 9);
    step(10);
    chk("burst_occupancy_hold", occupancy, 9);
    chk("burst_tdata_first", m_tdata, 32'h0000_0100);
    m_tready = 1'b1;
    wait_drain("burst_drain", 200, 1'b0);
    chk("burst_word_cnt", word_cnt, 20);
    chk("sat_word_cnt_final", cnt_s, 15);

    // Continuous vld: acks land exactly every other cycle
    pulse_reset();
    gap_pct = 0;
    for (int i = 0; i < 30; i++) tx_q.push_back(32'h5A00_0000 + i);
    step(4);
    nack = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ack) nack++;
    end
    chk("ack_spacing_count", nack, 10);
    wait_drain("spacing_drain", 300, 1'b0);

    // Random gaps and random ready
    gap_pct = 30;
    for (int i = 0; i < 10000; i++) tx_q.push_back($urandom);
    wait_drain("random_drain", 60000, 1'b1);
    m_tready = 1'b1;
    gap_pct = 0;

    // Reset in the middle of a backpressured burst
    pulse_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 12; i++) tx_q.push_back(32'hA000_0000 + i);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      if (occupancy == 4'd5) found = 1;
    end
    chk("midrst_reach_occ5", found, 1);
    chk("midrst_tvalid_before", m_tvalid, 1);
    head = tx_q[0];
    n_left = tx_q.size();
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_occupancy", occupancy, 0);
    chk("midrst_word_cnt", word_cnt, 0);
    chk("midrst_ack", ack, 0);
    step(3);
    rst = 1'b0;
    m_tready = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (m_tvalid) found = 1;
    end
    chk("midrst_output_seen", found, 1);
    chk("midrst_first_word", m_tdata, head);
    wait_drain("midrst_drain", 200, 1'b0);
    chk("midrst_word_cnt_after", word_cnt, n_left);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
